// File: rtl/esfa_bench_seq.sv
// Multi-run benchmark sequencer for the ESFA core: launches NUM_RUNS runs, times each one,
// enforces a per-run timeout and keeps pass/fail/timeout statistics.
// Optional min/max tracking of passing runs is enabled by defining ESFA_BENCH_STATS_EN.
module esfa_bench_seq #(
   parameter int unsigned NUM_RUNS   = 4,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned TIMEOUT    = 40000,
   parameter int unsigned START_WAIT = 8,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             run_req,
   input  logic             core_running,
   input  logic             core_success,
   output logic [15:0]      pass_count,
   output logic [15:0]      fail_count,
   output logic [15:0]      timeout_count,
   output logic [CNT_W-1:0] last_cycles,
   output logic [CNT_W-1:0] min_cycles,
   output logic [CNT_W-1:0] max_cycles
);

   typedef enum logic [2:0] {StIdle, StLaunch, StRun, StGap, StDone} state_e;

   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(START_WAIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [15:0]      RUNS_C    = 16'(NUM_RUNS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      idx_q, idx_d;
   logic [15:0]      pass_q, pass_d;
   logic [15:0]      fail_q, fail_d;
   logic [15:0]      tmo_q, tmo_d;
   logic [CNT_W-1:0] last_q, last_d;
   logic             run_req_q, run_req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // cnt_q is shared: launch wait in StLaunch, run length in StRun, gap length in StGap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      tmo_d   = tmo_q;
      last_d  = last_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLaunch;
               cnt_d   = CNT_ZERO;
               idx_d   = 16'd0;
               pass_d  = 16'd0;
               fail_d  = 16'd0;
               tmo_d   = 16'd0;
               last_d  = CNT_ZERO;
            end
         end
         StLaunch: begin
            if (core_running) begin
               state_d = StRun;
               cnt_d   = CNT_ONE;
            end else if (cnt_q >= WAIT_LAST) begin
               state_d = StGap;
               cnt_d   = CNT_ZERO;
               fail_d  = sat_inc16(fail_q);
               last_d  = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         StRun: begin
            // A fall on the cycle the counter hits TIMEOUT is a normal completion.
            if (!core_running) begin
               state_d = StGap;
               cnt_d   = CNT_ZERO;
               last_d  = cnt_q;
               if (core_success) pass_d = sat_inc16(pass_q);
               else              fail_d = sat_inc16(fail_q);
            end else if (cnt_q >= TIMEOUT_C) begin
               state_d = StGap;
               cnt_d   = CNT_ZERO;
               last_d  = TIMEOUT_C;
               tmo_d   = sat_inc16(tmo_q);
               fail_d  = sat_inc16(fail_q);
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         StGap: begin
            // Never relaunch into a core that is still running.
            if (cnt_q >= GAP_LAST && !core_running) begin
               cnt_d = CNT_ZERO;
               idx_d = idx_q + 16'd1;
               if (idx_q + 16'd1 == RUNS_C) state_d = StDone;
               else                         state_d = StLaunch;
            end else if (cnt_q < GAP_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      run_req_d = (state_d == StLaunch) || (state_d == StRun);
      busy_d    = (state_d != StIdle);
      done_d    = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         tmo_q     <= '0;
         last_q    <= '0;
         run_req_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         tmo_q     <= tmo_d;
         last_q    <= last_d;
         run_req_q <= run_req_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef ESFA_BENCH_STATS_EN
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic             clear_stats;
   logic             pass_rec;

   assign clear_stats = (state_q == StIdle) && start;
   assign pass_rec    = (state_q == StRun) && !core_running && core_success;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (clear_stats) begin
         min_d = '1;
         max_d = '0;
      end else if (pass_rec) begin
         if (cnt_q < min_q) min_d = cnt_q;
         if (cnt_q > max_q) max_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         min_q <= '1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min_cycles = min_q;
   assign max_cycles = max_q;
`else
   assign min_cycles = '0;
   assign max_cycles = '0;
`endif

   assign busy          = busy_q;
   assign done          = done_q;
   assign run_req       = run_req_q;
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign timeout_count = tmo_q;
   assign last_cycles   = last_q;

   req_implies_busy: assert property (@(posedge clk) disable iff (!reset) run_req |-> busy);
   done_implies_busy: assert property (@(posedge clk) disable iff (!reset) done |-> busy);

endmodule

// File: tb/tb_esfa_bench_seq.sv
// Directed bench for esfa_bench_seq: a behavioural core answers run_req with runs of chosen
// length and outcome; each scenario checks the resulting statistics and handshake timing.
module tb_esfa_bench_seq;

   localparam int unsigned CNT_W = 32;
`ifdef ESFA_BENCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             busy;
   logic             done;
   logic             run_req;
   logic             core_running;
   logic             core_success;
   logic [15:0]      pass_count;
   logic [15:0]      fail_count;
   logic [15:0]      timeout_count;
   logic [CNT_W-1:0] last_cycles;
   logic [CNT_W-1:0] min_cycles;
   logic [CNT_W-1:0] max_cycles;

   int total = 0;
   int bad = 0;
   int done_total = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_total = done_total + 1;

   esfa_bench_seq #(
      .NUM_RUNS  (3),
      .CNT_W     (CNT_W),
      .TIMEOUT   (200),
      .START_WAIT(8),
      .GAP_CYCLES(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .run_req      (run_req),
      .core_running (core_running),
      .core_success (core_success),
      .pass_count   (pass_count),
      .fail_count   (fail_count),
      .timeout_count(timeout_count),
      .last_cycles  (last_cycles),
      .min_cycles   (min_cycles),
      .max_cycles   (max_cycles)
   );

   task automatic do_start;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_run_req(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (run_req === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL run_req_rise: got 0 want 1 within 100 cycles");
      end
   endtask

   task automatic wait_done;
      bit seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_rise: got 0 want 1 within 3000 cycles");
      end
   endtask

   // Core model: holds core_running for len sampled edges, then drops it with success=ok.
   task automatic run_core(input int len, input bit ok, input int pulse_at, input bit pulse_gap);
      bit seen;
      wait_run_req(seen);
      if (!seen) return;
      core_running = 1'b1;
      for (int i = 1; i <= len; i++) begin
         @(negedge clk);
         start = (i == pulse_at);
      end
      start        = 1'b0;
      core_running = 1'b0;
      core_success = ok;
      if (pulse_gap) begin
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic test_reset;
      total++; if (run_req !== 1'b0) begin bad++; $display("FAIL rst_run_req: got %0b want 0", run_req); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
      total++; if (pass_count !== 16'd0) begin bad++; $display("FAIL rst_pass: got %0d want 0", pass_count); end
      total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL rst_fail: got %0d want 0", fail_count); end
      total++; if (timeout_count !== 16'd0) begin bad++; $display("FAIL rst_tmo: got %0d want 0", timeout_count); end
      total++; if (last_cycles !== 32'd0) begin bad++; $display("FAIL rst_last: got %0d want 0", last_cycles); end
      total++; if (min_cycles !== (STATS ? 32'hFFFF_FFFF : 32'd0)) begin bad++; $display("FAIL rst_min: got %0h want %0h", min_cycles, STATS ? 32'hFFFF_FFFF : 32'd0); end
      total++; if (max_cycles !== 32'd0) begin bad++; $display("FAIL rst_max: got %0d want 0", max_cycles); end
   endtask

   task automatic test_pass_runs;
      int d0 = done_total;
      do_start;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pass_busy_start: got %0b want 1", busy); end
      run_core(100, 1'b1, 0, 1'b0);
      run_core(50, 1'b1, 0, 1'b0);
      run_core(75, 1'b1, 0, 1'b0);
      wait_done;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pass_busy_at_done: got %0b want 1", busy); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL pass_busy_after_done: got %0b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL pass_done_width: got %0b want 0", done); end
      @(negedge clk);
      total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL pass_done_count: got %0d want 1", done_total - d0); end
      total++; if (pass_count !== 16'd3) begin bad++; $display("FAIL pass_pass: got %0d want 3", pass_count); end
      total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL pass_fail: got %0d want 0", fail_count); end
      total++; if (timeout_count !== 16'd0) begin bad++; $display("FAIL pass_tmo: got %0d want 0", timeout_count); end
      total++; if (last_cycles !== 32'd75) begin bad++; $display("FAIL pass_last: got %0d want 75", last_cycles); end
      total++; if (min_cycles !== (STATS ? 32'd50 : 32'd0)) begin bad++; $display("FAIL pass_min: got %0d want %0d", min_cycles, STATS ? 50 : 0); end
      total++; if (max_cycles !== (STATS ? 32'd100 : 32'd0)) begin bad++; $display("FAIL pass_max: got %0d want %0d", max_cycles, STATS ? 100 : 0); end
   endtask

   task automatic test_no_start;
      int d0 = done_total;
      int n;
      do_start;
      n = (run_req === 1'b1) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (run_req === 1'b1) n++;
         else break;
      end
      total++; if (n != 8) begin bad++; $display("FAIL nostart_wait_len: got %0d want 8", n); end
      wait_done;
      @(negedge clk);
      @(negedge clk);
      total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL nostart_done_count: got %0d want 1", done_total - d0); end
      total++; if (fail_count !== 16'd3) begin bad++; $display("FAIL nostart_fail: got %0d want 3", fail_count); end
      total++; if (pass_count !== 16'd0) begin bad++; $display("FAIL nostart_pass: got %0d want 0", pass_count); end
      total++; if (timeout_count !== 16'd0) begin bad++; $display("FAIL nostart_tmo: got %0d want 0", timeout_count); end
      total++; if (last_cycles !== 32'd0) begin bad++; $display("FAIL nostart_last: got %0d want 0", last_cycles); end
      total++; if (max_cycles !== 32'd0) begin bad++; $display("FAIL nostart_max: got %0d want 0", max_cycles); end
   endtask

   task automatic test_timeout;
      bit seen;
      do_start;
      wait_run_req(seen);
      core_running = 1'b1;
      core_success = 1'b1;
      repeat (250) @(negedge clk);
      total++; if (run_req !== 1'b0) begin bad++; $display("FAIL tmo_run_req_gap: got %0b want 0", run_req); end
      total++; if (timeout_count !== 16'd1) begin bad++; $display("FAIL tmo_tmo: got %0d want 1", timeout_count); end
      total++; if (fail_count !== 16'd1) begin bad++; $display("FAIL tmo_fail: got %0d want 1", fail_count); end
      total++; if (pass_count !== 16'd0) begin bad++; $display("FAIL tmo_pass: got %0d want 0", pass_count); end
      total++; if (last_cycles !== 32'd200) begin bad++; $display("FAIL tmo_last: got %0d want 200", last_cycles); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_busy: got %0b want 1", busy); end
      repeat (49) @(negedge clk);
      total++; if (run_req !== 1'b0) begin bad++; $display("FAIL tmo_stall: got %0b want 0", run_req); end
      @(negedge clk);
      core_running = 1'b0;
      run_core(10, 1'b1, 0, 1'b0);
      run_core(20, 1'b1, 0, 1'b0);
      wait_done;
      @(negedge clk);
      total++; if (pass_count !== 16'd2) begin bad++; $display("FAIL tmo_end_pass: got %0d want 2", pass_count); end
      total++; if (fail_count !== 16'd1) begin bad++; $display("FAIL tmo_end_fail: got %0d want 1", fail_count); end
      total++; if (timeout_count !== 16'd1) begin bad++; $display("FAIL tmo_end_tmo: got %0d want 1", timeout_count); end
      total++; if (last_cycles !== 32'd20) begin bad++; $display("FAIL tmo_end_last: got %0d want 20", last_cycles); end
      total++; if (min_cycles !== (STATS ? 32'd10 : 32'd0)) begin bad++; $display("FAIL tmo_min: got %0d want %0d", min_cycles, STATS ? 10 : 0); end
      total++; if (max_cycles !== (STATS ? 32'd20 : 32'd0)) begin bad++; $display("FAIL tmo_max: got %0d want %0d", max_cycles, STATS ? 20 : 0); end
   endtask

   task automatic test_exact_timeout;
      do_start;
      run_core(5, 1'b1, 0, 1'b0);
      run_core(5, 1'b1, 0, 1'b0);
      run_core(200, 1'b1, 0, 1'b0);
      wait_done;
      @(negedge clk);
      total++; if (pass_count !== 16'd3) begin bad++; $display("FAIL exact_pass: got %0d want 3", pass_count); end
      total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL exact_fail: got %0d want 0", fail_count); end
      total++; if (timeout_count !== 16'd0) begin bad++; $display("FAIL exact_tmo: got %0d want 0", timeout_count); end
      total++; if (last_cycles !== 32'd200) begin bad++; $display("FAIL exact_last: got %0d want 200", last_cycles); end
      total++; if (min_cycles !== (STATS ? 32'd5 : 32'd0)) begin bad++; $display("FAIL exact_min: got %0d want %0d", min_cycles, STATS ? 5 : 0); end
      total++; if (max_cycles !== (STATS ? 32'd200 : 32'd0)) begin bad++; $display("FAIL exact_max: got %0d want %0d", max_cycles, STATS ? 200 : 0); end
   endtask

   task automatic test_ignored_start;
      int d0 = done_total;
      do_start;
      run_core(40, 1'b0, 10, 1'b1);
      run_core(30, 1'b1, 0, 1'b0);
      run_core(20, 1'b1, 0, 1'b0);
      wait_done;
      @(negedge clk);
      @(negedge clk);
      total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", done_total - d0); end
      total++; if (pass_count !== 16'd2) begin bad++; $display("FAIL ign_pass: got %0d want 2", pass_count); end
      total++; if (fail_count !== 16'd1) begin bad++; $display("FAIL ign_fail: got %0d want 1", fail_count); end
      total++; if (timeout_count !== 16'd0) begin bad++; $display("FAIL ign_tmo: got %0d want 0", timeout_count); end
      total++; if (last_cycles !== 32'd20) begin bad++; $display("FAIL ign_last: got %0d want 20", last_cycles); end
      total++; if (min_cycles !== (STATS ? 32'd20 : 32'd0)) begin bad++; $display("FAIL ign_min: got %0d want %0d", min_cycles, STATS ? 20 : 0); end
      total++; if (max_cycles !== (STATS ? 32'd30 : 32'd0)) begin bad++; $display("FAIL ign_max: got %0d want %0d", max_cycles, STATS ? 30 : 0); end
   endtask

   task automatic test_reset_mid_run;
      bit seen;
      int d0;
      do_start;
      run_core(10, 1'b1, 0, 1'b0);
      wait_run_req(seen);
      core_running = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      total++; if (run_req !== 1'b0) begin bad++; $display("FAIL mid_run_req: got %0b want 0", run_req); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
      total++; if (pass_count !== 16'd0) begin bad++; $display("FAIL mid_pass: got %0d want 0", pass_count); end
      total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL mid_fail: got %0d want 0", fail_count); end
      total++; if (timeout_count !== 16'd0) begin bad++; $display("FAIL mid_tmo: got %0d want 0", timeout_count); end
      total++; if (last_cycles !== 32'd0) begin bad++; $display("FAIL mid_last: got %0d want 0", last_cycles); end
      total++; if (min_cycles !== (STATS ? 32'hFFFF_FFFF : 32'd0)) begin bad++; $display("FAIL mid_min: got %0h want %0h", min_cycles, STATS ? 32'hFFFF_FFFF : 32'd0); end
      total++; if (max_cycles !== 32'd0) begin bad++; $display("FAIL mid_max: got %0d want 0", max_cycles); end
      core_running = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      d0 = done_total;
      do_start;
      run_core(10, 1'b1, 0, 1'b0);
      run_core(20, 1'b1, 0, 1'b0);
      run_core(30, 1'b1, 0, 1'b0);
      wait_done;
      @(negedge clk);
      @(negedge clk);
      total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL fresh_done_count: got %0d want 1", done_total - d0); end
      total++; if (pass_count !== 16'd3) begin bad++; $display("FAIL fresh_pass: got %0d want 3", pass_count); end
      total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL fresh_fail: got %0d want 0", fail_count); end
      total++; if (last_cycles !== 32'd30) begin bad++; $display("FAIL fresh_last: got %0d want 30", last_cycles); end
      total++; if (min_cycles !== (STATS ? 32'd10 : 32'd0)) begin bad++; $display("FAIL fresh_min: got %0d want %0d", min_cycles, STATS ? 10 : 0); end
   endtask

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      core_running = 1'b0;
      core_success = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset = 1'b1;
      @(negedge clk);
      test_pass_runs;
      test_no_start;
      test_timeout;
      test_exact_timeout;
      test_ignored_start;
      test_reset_mid_run;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
